// File: rtl/loader_pkg.sv
// Shared types and framing constants for the byte-stream program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_HDR0  = 3'd0,
        ST_HDR1  = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CSUM  = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // Shortest possible frame in cycles: header, 4 bytes + 1 write cycle per word, checksum.
    function automatic int min_frame_cycles(input int n_words);
        return HDR_BYTES + (BYTES_PER_WORD + 1) * n_words + 1;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles four little-endian bytes into one 32-bit word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;

    // Shift right so the first byte of a word lands in bits [7:0] after four pushes.
    always_comb begin
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        word       = {byte_in, sr_q[31:8]};
        word_valid = push && (cnt_q == 2'(BYTES_PER_WORD - 1));
        if (clear) begin
            cnt_d = 2'd0;
            sr_d  = 32'd0;
        end else if (push) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = word;
        end
    end

    // Counter and assembly register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= 2'd0;
            sr_q  <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: holds the CPU in reset and owns the memory port
// until a complete, checksum-verified program has been written.
//
// state | meaning
// HDR0  | waiting for word count low byte
// HDR1  | waiting for word count high byte, range-checked on accept
// DATA  | collecting payload bytes into the packer
// WRITE | one-cycle memory write of the assembled word
// CSUM  | waiting for the XOR checksum byte
// DONE  | load verified, CPU released, memory handed back
// ERR   | bad count or checksum, CPU held until reset
module prog_loader
    import loader_pkg::*;
#(
    parameter int Width = 32,
    parameter int DEPTH = 128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             ext_sel,
    output logic             mem_we,
    output logic [31:0]      mem_adr,
    output logic [Width-1:0] mem_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [7:0]         n_lo_q, n_lo_d;
    logic [15:0]        n_q, n_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic [7:0]         csum_q, csum_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_adr_q, mem_adr_d;
    logic [Width-1:0]   mem_wdata_q, mem_wdata_d;

    logic        accept;
    logic [15:0] hdr_n;
    logic        n_bad;
    logic        last_word;
    logic        pk_valid;
    logic [31:0] pk_word;

    assign accept    = in_valid && in_ready;
    assign hdr_n     = {in_data, n_lo_q};
    assign n_bad     = (hdr_n == 16'd0) || (hdr_n > 16'(DEPTH));
    assign last_word = (16'(word_idx_q) + 16'd1) == n_q;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      ((state_q == ST_HDR1) && accept),
        .push       ((state_q == ST_DATA) && accept),
        .byte_in    (in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_HDR0;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HDR0:  if (accept) state_d = ST_HDR1;
            ST_HDR1:  if (accept) state_d = n_bad ? ST_ERR : ST_DATA;
            ST_DATA:  if (pk_valid) state_d = ST_WRITE;
            ST_WRITE: state_d = last_word ? ST_CSUM : ST_DATA;
            ST_CSUM:  if (accept) state_d = (in_data == csum_q) ? ST_DONE : ST_ERR;
            ST_DONE:  state_d = ST_DONE;
            ST_ERR:   state_d = ST_ERR;
            default:  state_d = ST_ERR;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        in_ready = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                   (state_q == ST_DATA) || (state_q == ST_CSUM);
        ext_sel  = (state_q != ST_DONE);
        cpu_hold = (state_q != ST_DONE);
        done     = (state_q == ST_DONE);
        err      = (state_q == ST_ERR);
    end

    // Datapath: count capture, checksum, word index and registered memory port.
    always_comb begin
        n_lo_d      = n_lo_q;
        n_d         = n_q;
        word_idx_d  = word_idx_q;
        csum_d      = csum_q;
        mem_we_d    = 1'b0;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            ST_HDR0: if (accept) n_lo_d = in_data;
            ST_HDR1: begin
                if (accept) begin
                    n_d        = hdr_n;
                    word_idx_d = '0;
                    csum_d     = 8'd0;
                end
            end
            ST_DATA: begin
                if (accept) csum_d = csum_q ^ in_data;
                if (pk_valid) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = Width'(pk_word);
                    mem_adr_d   = {{(32-IDX_W-2){1'b0}}, word_idx_q, 2'b00};
                end
            end
            ST_WRITE: if (!last_word) word_idx_d = word_idx_q + 1'b1;
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            n_lo_q      <= 8'd0;
            n_q         <= 16'd0;
            word_idx_q  <= '0;
            csum_q      <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= 32'd0;
            mem_wdata_q <= '0;
        end else begin
            n_lo_q      <= n_lo_d;
            n_q         <= n_d;
            word_idx_q  <= word_idx_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_adr   = mem_adr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
